// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufz_bus_pkg.sv
// Shared types and limits for the arbitrated tristate bus driver.
package gf180mcu_fd_sc_mcu7t5v0__bufz_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int TA_MIN      = 1;
  localparam int TA_MAX      = 15;
  localparam int MAXHOLD_MIN = 0;
  localparam int MAXHOLD_MAX = 255;

  // Counter width able to hold 0..maxval, never narrower than one bit.
  function automatic int cnt_w(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufz_bus_rrarb.sv
// Round-robin arbiter: first requester after ptr_i wins, ptr_i itself is searched last.
module gf180mcu_fd_sc_mcu7t5v0__bufz_bus_rrarb
  import gf180mcu_fd_sc_mcu7t5v0__bufz_bus_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  idx_o
);

  int   c;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 1; i <= NCH; i++) begin
      c = (int'(ptr_i) + i) % NCH;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufz_bus.sv
// Multi-channel tristate bus with round-robin grant, hold limit and turnaround gap.
// Optional bus keeper: GF180MCU_FD_SC_MCU7T5V0__BUFZ_BUS_KEEPER_EN.
module gf180mcu_fd_sc_mcu7t5v0__bufz_bus
  import gf180mcu_fd_sc_mcu7t5v0__bufz_bus_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NCH     = 4,
  parameter int TA      = 1,
  parameter int MAXHOLD = 0
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic [NCH-1:0]       REQ,
  input  logic [NCH*WIDTH-1:0] I,
  output logic [NCH-1:0]       GNT,
  output logic                 OE,
  output logic [WIDTH-1:0]     Z
);

  localparam int IW = $clog2(NCH);
  localparam int HW = cnt_w(MAXHOLD);
  localparam int TW = cnt_w(TA);

  state_e           state_q;
  logic [NCH-1:0]   gnt_q;
  logic             oe_q;
  logic [IW-1:0]    ptr_q;
  logic [HW-1:0]    hold_q;
  logic [TW-1:0]    ta_q;
  logic [WIDTH-1:0] z_q;

  logic [NCH-1:0]   arb_gnt_s;
  logic [IW-1:0]    arb_idx_s;
  logic [WIDTH-1:0] cur_data_s;
  logic [HW-1:0]    hold_inc_s;
  logic             others_s;
  logic             hold_lim_s;
  logic             drive_exit_s;
  logic             ta_last_s;

  gf180mcu_fd_sc_mcu7t5v0__bufz_bus_rrarb #(
    .NCH (NCH),
    .IW  (IW)
  ) u_rrarb (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s)
  );

  assign cur_data_s   = I[int'(ptr_q)*WIDTH +: WIDTH];
  assign hold_inc_s   = (hold_q == HW'(MAXHOLD)) ? hold_q : hold_q + HW'(1);
  assign others_s     = |(REQ & ~gnt_q);
  // Hold limit fires on the edge that would bring the count up to MAXHOLD.
  assign hold_lim_s   = (MAXHOLD > 0) && (hold_inc_s == HW'(MAXHOLD)) && others_s;
  assign drive_exit_s = !REQ[ptr_q] || hold_lim_s;
  assign ta_last_s    = (ta_q == TW'(TA - 1));

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      oe_q    <= 1'b0;
      ptr_q   <= IW'(NCH - 1);
      hold_q  <= '0;
      ta_q    <= '0;
      z_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|REQ) begin
            state_q <= ST_DRIVE;
            gnt_q   <= arb_gnt_s;
            oe_q    <= 1'b1;
            ptr_q   <= arb_idx_s;
            hold_q  <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          // The exit edge does not load z_q, so a keeper holds what was on the bus.
          if (drive_exit_s) begin
            state_q <= ST_TURN;
            gnt_q   <= '0;
            oe_q    <= 1'b0;
            ta_q    <= '0;
          end else begin
            z_q    <= cur_data_s;
            hold_q <= hold_inc_s;
          end
        end
        ST_TURN: begin
          if (!ta_last_s) begin
            ta_q <= ta_q + TW'(1);
          end else if (|REQ) begin
            state_q <= ST_DRIVE;
            gnt_q   <= arb_gnt_s;
            oe_q    <= 1'b1;
            ptr_q   <= arb_idx_s;
            hold_q  <= '0;
            ta_q    <= '0;
          end else begin
            state_q <= ST_IDLE;
            ta_q    <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          oe_q    <= 1'b0;
          ta_q    <= '0;
        end
      endcase
    end
  end

  assign GNT = gnt_q;
  assign OE  = oe_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_BUS_KEEPER_EN
  assign Z = z_q;
`else
  assign Z = oe_q ? z_q : {WIDTH{1'bz}};
`endif

`ifndef FUNCTIONAL
  specify
    (CLK *> Z)   = (1.0, 1.0);
    (CLK *> GNT) = (1.0, 1.0);
    (CLK => OE)  = (1.0, 1.0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__bufz_bus.sv
// Directed bench for the arbitrated tristate bus (TA=3, MAXHOLD=4) plus a random-REQ invariant phase.
module tb_gf180mcu_fd_sc_mcu7t5v0__bufz_bus;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int TA_P = 3;
  localparam int MH_P = 4;

  logic         CLK;
  logic         RN;
  logic [N-1:0] REQ;
  logic [N*W-1:0] I;
  wire  [N-1:0] GNT;
  wire          OE;
  wire  [W-1:0] Z;

  int vectors     = 0;
  int miscompares = 0;

  int gap      = 0;
  bit seen     = 1'b0;
  bit prev_oe  = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__bufz_bus #(
    .WIDTH   (W),
    .NCH     (N),
    .TA      (TA_P),
    .MAXHOLD (MH_P)
  ) dut (
    .CLK (CLK),
    .RN  (RN),
    .REQ (REQ),
    .I   (I),
    .GNT (GNT),
    .OE  (OE),
    .Z   (Z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_released(input string tag);
    chk({tag, "_gnt"}, {28'd0, GNT}, 32'd0);
    chk({tag, "_oe"}, {31'd0, OE}, 32'd0);
  endtask

  // Invariants: one-hot grant, OE tracks GNT, at least TA dead cycles between drivers.
  always @(negedge CLK) begin
    if (!RN) begin
      seen    = 1'b0;
      gap     = 0;
      prev_oe = 1'b0;
    end else begin
      vectors++;
      assert (($countones(GNT) <= 1) && (OE === (|GNT))) else begin
        miscompares++;
        $error("FAIL inv_onehot: observed GNT=%b OE=%b expected onehot and OE=|GNT", GNT, OE);
      end
      if (OE) begin
        if (!prev_oe && seen) begin
          vectors++;
          assert (gap >= TA_P) else begin
            miscompares++;
            $error("FAIL inv_gap: observed %0d expected >= %0d", gap, TA_P);
          end
        end
        seen = 1'b1;
        gap  = 0;
      end else begin
        gap++;
      end
      prev_oe = OE;
    end
  end

  initial begin
    RN  = 1'b0;
    REQ = 4'b0101;
    I   = {8'h5A, 8'hC3, 8'h3C, 8'hA5};

    // Reset state, and no grant while RN is low even across edges.
    #2;
    chk_released("rst");
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_BUS_KEEPER_EN
    chk("rst_z_keep", {24'd0, Z}, 32'h0000_0000);
`endif
    #20;
    chk_released("rst_hold");
    RN = 1'b1;

    // First grant goes to ch0; data appears one edge later.
    step();
    chk("g1_gnt", {28'd0, GNT}, 32'h1);
    chk("g1_oe", {31'd0, OE}, 32'h1);
    step();
    chk("g1_z", {24'd0, Z}, 32'hA5);

    // ch0 drops with ch2 pending: exactly TA cycles released.
    REQ = 4'b0100;
    step();
    chk_released("ta1");
    step();
    chk_released("ta2");
    step();
    chk_released("ta3");
    step();
    chk("g2_gnt", {28'd0, GNT}, 32'h4);
    step();
    chk("g2_z", {24'd0, Z}, 32'hC3);

    // Non-granted activity must not disturb the owner; owner data follows with latency 1.
    I   = {8'h5A, 8'h99, 8'h3C, 8'hFF};
    REQ = 4'b1100;
    step();
    chk("own_gnt", {28'd0, GNT}, 32'h4);
    chk("own_z", {24'd0, Z}, 32'h99);

    // Release to IDLE.
    REQ = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_released("idle");
    end

    // Hold limit: two requesters alternate every MAXHOLD cycles with TA gaps.
    REQ = 4'b0011;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < MH_P; k++) begin
        step();
        chk("hold_gnt", {28'd0, GNT}, (r % 2 == 0) ? 32'h1 : 32'h2);
      end
      for (int k = 0; k < TA_P; k++) begin
        step();
        chk_released("hold_turn");
      end
    end

    // ch1 drives 8'h3C then releases.
    REQ = 4'b0010;
    step();
    chk("k_gnt", {28'd0, GNT}, 32'h2);
    step();
    chk("k_z", {24'd0, Z}, 32'h3C);
    REQ = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_BUS_KEEPER_EN
      chk("k_keep", {24'd0, Z}, 32'h3C);
`else
      chk_released("k_rel");
`endif
    end

    // Reset in the middle of DRIVE releases the bus before the next edge.
    REQ = 4'b0001;
    step();
    chk("r_gnt", {28'd0, GNT}, 32'h1);
    step();
    chk("r_z", {24'd0, Z}, 32'hFF);
    #2;
    RN = 1'b0;
    #1;
    chk_released("r_async");
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFZ_BUS_KEEPER_EN
    chk("r_z_keep", {24'd0, Z}, 32'h0000_0000);
`endif
    REQ = 4'b1000;
    step();
    chk_released("r_held");
    RN = 1'b1;
    step();
    chk("r_ch3_gnt", {28'd0, GNT}, 32'h8);
    chk("r_ch3_oe", {31'd0, OE}, 32'h1);
    step();
    chk("r_ch3_z", {24'd0, Z}, 32'h5A);

    // Sole requester is never cut off by the hold limit.
    for (int k = 0; k < 6; k++) begin
      step();
    end
    chk("sat_gnt", {28'd0, GNT}, 32'h8);

    // Released ch3 re-requests during TURN and loses to ch2.
    REQ = 4'b0000;
    step();
    chk_released("rr_exit");
    REQ = 4'b1100;
    step();
    step();
    chk_released("rr_turn");
    step();
    chk("rr_gnt", {28'd0, GNT}, 32'h4);

    // Random requests; invariants are checked by the negedge monitor.
    for (int k = 0; k < 2000; k++) begin
      REQ = 4'($urandom_range(0, 15));
      I   = $urandom();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
